board_ram_arbiter: RTL and testbench

Single-port owner of the 32768x3 board RAM (address = X[14:7], Y[6:0]). It time-shares the RAM between two requesters: the game collision/update logic (read-modify-write of player cells) and the VGA redraw reader. It also contains a built-in board-clear sequencer for new-round reset. It sits between those clients and the RAM instance, and is the only driver of the RAM's address, data and wren inputs.

---
 rtl/board_ram_arbiter.sv | 172 +++++++++++++++++
 tb/tb_board_ram_arbiter.sv | 357 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/board_ram_arbiter.sv
// Single-port owner of the 32768x3 board RAM: arbitrates game RMW and VGA reads,
// and runs a full-board clear sweep on request.
module board_ram_arbiter #(
  parameter int unsigned BOARD_W      = 160,
  parameter int unsigned BOARD_H      = 120,
  parameter int unsigned RD_LAT       = 1,
  parameter int unsigned VGA_MAX_WAIT = 8
) (
  input  logic        CLOCK_50,
  input  logic        reset,
  input  logic        game_req,
  input  logic        game_wr,
  input  logic [14:0] game_addr,
  input  logic [2:0]  game_wdata,
  output logic        game_gnt,
  output logic        game_rvalid,
  input  logic        vga_req,
  input  logic [14:0] vga_addr,
  output logic        vga_gnt,
  output logic        vga_rvalid,
  output logic [2:0]  rdata,
  input  logic        clear_start,
  output logic        clear_busy,
  output logic        clear_done,
  output logic [14:0] ram_address,
  output logic [2:0]  ram_data,
  output logic        ram_wren,
  input  logic [2:0]  ram_q
);

  localparam int unsigned WaitW = $clog2(VGA_MAX_WAIT + 1);
  localparam logic [WaitW-1:0] WaitMax = WaitW'(VGA_MAX_WAIT);
  localparam logic [7:0] XLast = 8'(BOARD_W - 1);
  localparam logic [6:0] YLast = 7'(BOARD_H - 1);

  typedef enum logic [0:0] {StIdle, StClear} state_e;

  state_e           state_q, state_d;
  logic [7:0]       x_q, x_d;
  logic [6:0]       y_q, y_d;
  logic [WaitW-1:0] wait_q, wait_d;
  logic [14:0]      addr_q, addr_d;
  logic [2:0]       data_q, data_d;
  logic             wren_q, wren_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic [RD_LAT:0]  tag_vld_q, tag_vld_d;
  logic [RD_LAT:0]  tag_vga_q, tag_vga_d;
  logic             game_rvalid_q, game_rvalid_d;
  logic             vga_rvalid_q, vga_rvalid_d;

  logic arb_en, forced, game_win, vga_win, issue_rd, issue_vga;

  always_comb begin
    state_d   = state_q;
    x_d       = x_q;
    y_d       = y_q;
    wait_d    = wait_q;
    addr_d    = addr_q;
    data_d    = data_q;
    wren_d    = 1'b0;
    busy_d    = busy_q;
    done_d    = 1'b0;
    issue_rd  = 1'b0;
    issue_vga = 1'b0;

    // A waiting VGA client that has hit its limit overrides game priority.
    arb_en   = (state_q == StIdle) && !clear_start;
    forced   = vga_req && (wait_q == WaitMax);
    game_win = arb_en && game_req && !forced;
    vga_win  = arb_en && vga_req && !game_win;

    unique case (state_q)
      StIdle: begin
        if (clear_start) begin
          state_d = StClear;
          x_d     = '0;
          y_d     = '0;
          busy_d  = 1'b1;
        end else if (game_win) begin
          addr_d   = game_addr;
          wren_d   = game_wr;
          data_d   = game_wr ? game_wdata : 3'b000;
          issue_rd = !game_wr;
        end else if (vga_win) begin
          addr_d    = vga_addr;
          data_d    = 3'b000;
          issue_rd  = 1'b1;
          issue_vga = 1'b1;
        end
      end
      StClear: begin
        addr_d = {x_q, y_q};
        data_d = 3'b000;
        wren_d = 1'b1;
        if (y_q == YLast) begin
          y_d = '0;
          if (x_q == XLast) begin
            x_d     = '0;
            state_d = StIdle;
            busy_d  = 1'b0;
            done_d  = 1'b1;
          end else begin
            x_d = x_q + 8'd1;
          end
        end else begin
          y_d = y_q + 7'd1;
        end
      end
    endcase

    if (vga_req && !vga_win) begin
      wait_d = (wait_q == WaitMax) ? wait_q : wait_q + WaitW'(1);
    end else begin
      wait_d = '0;
    end

    // Read tags ride alongside the RAM latency; the output stage lines up with ram_q.
    tag_vld_d[0] = issue_rd;
    tag_vga_d[0] = issue_vga;
    for (int unsigned i = 1; i <= RD_LAT; i++) begin
      tag_vld_d[i] = tag_vld_q[i-1];
      tag_vga_d[i] = tag_vga_q[i-1];
    end
    game_rvalid_d = tag_vld_q[RD_LAT] && !tag_vga_q[RD_LAT];
    vga_rvalid_d  = tag_vld_q[RD_LAT] && tag_vga_q[RD_LAT];
  end

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      state_q       <= StIdle;
      x_q           <= '0;
      y_q           <= '0;
      wait_q        <= '0;
      addr_q        <= '0;
      data_q        <= '0;
      wren_q        <= 1'b0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      tag_vld_q     <= '0;
      tag_vga_q     <= '0;
      game_rvalid_q <= 1'b0;
      vga_rvalid_q  <= 1'b0;
    end else begin
      state_q       <= state_d;
      x_q           <= x_d;
      y_q           <= y_d;
      wait_q        <= wait_d;
      addr_q        <= addr_d;
      data_q        <= data_d;
      wren_q        <= wren_d;
      busy_q        <= busy_d;
      done_q        <= done_d;
      tag_vld_q     <= tag_vld_d;
      tag_vga_q     <= tag_vga_d;
      game_rvalid_q <= game_rvalid_d;
      vga_rvalid_q  <= vga_rvalid_d;
    end
  end

  assign game_gnt    = game_win;
  assign vga_gnt     = vga_win;
  assign game_rvalid = game_rvalid_q;
  assign vga_rvalid  = vga_rvalid_q;
  assign rdata       = ram_q;
  assign clear_busy  = busy_q;
  assign clear_done  = done_q;
  assign ram_address = addr_q;
  assign ram_data    = data_q;
  assign ram_wren    = wren_q;

endmodule

// File: tb/tb_board_ram_arbiter.sv
// Bench for board_ram_arbiter: RAM model, cycle-level behavioural reference checked every
// cycle, plus directed scenarios with hand-computed expectations.
module tb_board_ram_arbiter;

  localparam int unsigned W    = 160;
  localparam int unsigned H    = 120;
  localparam int unsigned LAT  = 1;
  localparam int unsigned MAXW = 8;

  logic        clk = 1'b0;
  logic        reset;
  logic        game_req, game_wr, game_gnt, game_rvalid;
  logic [14:0] game_addr;
  logic [2:0]  game_wdata;
  logic        vga_req, vga_gnt, vga_rvalid;
  logic [14:0] vga_addr;
  logic [2:0]  rdata;
  logic        clear_start, clear_busy, clear_done;
  logic [14:0] ram_address;
  logic [2:0]  ram_data, ram_q;
  logic        ram_wren;

  always #5 clk = ~clk;

  board_ram_arbiter #(
    .BOARD_W     (W),
    .BOARD_H     (H),
    .RD_LAT      (LAT),
    .VGA_MAX_WAIT(MAXW)
  ) dut (
    .CLOCK_50   (clk),
    .reset      (reset),
    .game_req   (game_req),
    .game_wr    (game_wr),
    .game_addr  (game_addr),
    .game_wdata (game_wdata),
    .game_gnt   (game_gnt),
    .game_rvalid(game_rvalid),
    .vga_req    (vga_req),
    .vga_addr   (vga_addr),
    .vga_gnt    (vga_gnt),
    .vga_rvalid (vga_rvalid),
    .rdata      (rdata),
    .clear_start(clear_start),
    .clear_busy (clear_busy),
    .clear_done (clear_done),
    .ram_address(ram_address),
    .ram_data   (ram_data),
    .ram_wren   (ram_wren),
    .ram_q      (ram_q)
  );

  // RAM: address register plus output register, so q for an address registered by the
  // arbiter at edge E0 is on ram_q after edge E0+2.
  logic [2:0]  mem [0:32767];
  logic [2:0]  shadow [0:32767];
  logic [14:0] ram_addr_r;
  logic [2:0]  ram_q_r;

  always @(posedge clk) begin
    if (ram_wren === 1'b1) mem[ram_address] <= ram_data;
    ram_addr_r <= ram_address;
    ram_q_r    <= mem[ram_addr_r];
  end
  assign ram_q = ram_q_r;

  initial begin
    for (int i = 0; i < 32768; i++) begin
      mem[i]    = 3'(i * 3);
      shadow[i] = 3'(i * 3);
    end
    mem[15'h1234]    = 3'b101;
    shadow[15'h1234] = 3'b101;
  end

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model state.
  typedef struct {
    int       due;
    bit       vga;
    logic [2:0] data;
  } rd_t;

  rd_t         rq[$];
  rd_t         ent;
  int          cyc = 0;
  bit          m_known = 0;
  bit          m_clearing;
  int          m_idx;
  int          m_wait;
  logic [14:0] m_addr;
  logic [2:0]  m_data;
  bit          m_wren, m_busy, m_done;
  bit          pg, pv, eg_rv, ev_rv;
  logic [2:0]  e_rd;

  always @(negedge clk) begin
    cyc++;
    pg = 0;
    pv = 0;
    if (!m_clearing && clear_start !== 1'b1) begin
      if (vga_req && (m_wait >= int'(MAXW) || !game_req)) pv = 1;
      else if (game_req) pg = 1;
    end
    eg_rv = 0;
    ev_rv = 0;
    e_rd  = '0;
    foreach (rq[i]) begin
      if (rq[i].due == cyc) begin
        if (rq[i].vga) ev_rv = 1;
        else eg_rv = 1;
        e_rd = rq[i].data;
      end
    end
    if (m_known) begin
      chk("game_gnt", game_gnt, pg);
      chk("vga_gnt", vga_gnt, pv);
      chk("ram_address", ram_address, m_addr);
      chk("ram_data", ram_data, m_data);
      chk("ram_wren", ram_wren, m_wren);
      chk("clear_busy", clear_busy, m_busy);
      chk("clear_done", clear_done, m_done);
      chk("game_rvalid", game_rvalid, eg_rv);
      chk("vga_rvalid", vga_rvalid, ev_rv);
      if (eg_rv || ev_rv) chk("rdata", rdata, e_rd);
    end
    while (rq.size() > 0 && rq[0].due <= cyc) void'(rq.pop_front());

    if (reset) begin
      m_known    = 1;
      m_clearing = 0;
      m_idx      = 0;
      m_wait     = 0;
      m_addr     = '0;
      m_data     = '0;
      m_wren     = 0;
      m_busy     = 0;
      m_done     = 0;
      rq.delete();
    end else if (m_known) begin
      m_done = 0;
      if (vga_req && !pv) m_wait = (m_wait < int'(MAXW)) ? m_wait + 1 : int'(MAXW);
      else m_wait = 0;
      if (m_clearing) begin
        m_addr = 15'((m_idx / int'(H)) * 128 + (m_idx % int'(H)));
        m_data = '0;
        m_wren = 1;
        shadow[m_addr] = '0;
        if (m_idx == int'(W * H) - 1) begin
          m_clearing = 0;
          m_busy     = 0;
          m_done     = 1;
        end else begin
          m_idx++;
        end
      end else if (clear_start) begin
        m_clearing = 1;
        m_idx      = 0;
        m_busy     = 1;
        m_wren     = 0;
      end else if (pg || pv) begin
        m_addr = pg ? game_addr : vga_addr;
        m_wren = pg && game_wr;
        m_data = m_wren ? game_wdata : 3'b000;
        if (m_wren) begin
          shadow[m_addr] = game_wdata;
        end else begin
          ent.due  = cyc + int'(LAT) + 2;
          ent.vga  = pv;
          ent.data = shadow[m_addr];
          rq.push_back(ent);
        end
      end else begin
        m_wren = 0;
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  int writes, done_cnt, gnt_in_clear;
  logic [14:0] last_addr;

  initial begin
    reset       = 1'b1;
    game_req    = 1'b0;
    game_wr     = 1'b0;
    game_addr   = '0;
    game_wdata  = '0;
    vga_req     = 1'b0;
    vga_addr    = '0;
    clear_start = 1'b0;
    step();
    step();
    reset = 1'b0;
    chk("rst ram_wren", ram_wren, 0);
    chk("rst ram_address", ram_address, 0);
    chk("rst clear_busy", clear_busy, 0);
    chk("rst rvalid", {game_rvalid, vga_rvalid}, 0);

    // Game read of a preloaded cell.
    game_req  = 1'b1;
    game_addr = 15'h1234;
    #1;
    chk("t1 game_gnt", game_gnt, 1);
    step();
    game_req = 1'b0;
    chk("t1 ram_address", ram_address, 15'h1234);
    step();
    chk("t1 early rvalid", game_rvalid, 0);
    step();
    chk("t1 game_rvalid", game_rvalid, 1);
    chk("t1 rdata", rdata, 3'b101);
    chk("t1 vga_rvalid", vga_rvalid, 0);
    step();

    // Both requesting: game wins MAXW times, then VGA is forced once.
    game_req  = 1'b1;
    game_addr = 15'h0100;
    vga_req   = 1'b1;
    vga_addr  = 15'h0200;
    for (int i = 0; i < 10; i++) begin
      #1;
      chk("t2 game_gnt", game_gnt, (i == 8) ? 0 : 1);
      chk("t2 vga_gnt", vga_gnt, (i == 8) ? 1 : 0);
      step();
    end
    game_req = 1'b0;
    vga_req  = 1'b0;
    repeat (4) step();

    // Write then read back the same cell.
    game_req   = 1'b1;
    game_wr    = 1'b1;
    game_addr  = 15'h0081;
    game_wdata = 3'b001;
    step();
    chk("t3 wr wren", ram_wren, 1);
    chk("t3 wr data", ram_data, 3'b001);
    game_wr = 1'b0;
    step();
    game_req = 1'b0;
    chk("t3 rd wren", ram_wren, 0);
    step();
    step();
    chk("t3 game_rvalid", game_rvalid, 1);
    chk("t3 rdata", rdata, 3'b001);
    step();

    // Full clear with VGA requesting throughout.
    vga_req     = 1'b1;
    vga_addr    = 15'h0300;
    clear_start = 1'b1;
    #1;
    chk("t4 vga_gnt at start", vga_gnt, 0);
    step();
    clear_start = 1'b0;
    chk("t4 clear_busy", clear_busy, 1);
    writes       = 0;
    done_cnt     = 0;
    gnt_in_clear = 0;
    last_addr    = '0;
    for (int i = 0; i < 20000; i++) begin
      step();
      if (ram_wren) begin
        writes++;
        if (writes == 1) chk("t4 first addr", ram_address, 15'h0000);
        last_addr = ram_address;
      end
      if (clear_done) begin
        done_cnt++;
        chk("t4 vga_gnt after clear", vga_gnt, 1);
        break;
      end else if (vga_gnt) begin
        gnt_in_clear++;
      end
    end
    chk("t4 writes", writes, 19200);
    chk("t4 last addr", last_addr, 15'h4FF7);
    chk("t4 done seen", done_cnt, 1);
    chk("t4 gnt during clear", gnt_in_clear, 0);
    step();
    vga_req = 1'b0;
    chk("t4 done pulse", clear_done, 0);
    chk("t4 vga addr", ram_address, 15'h0300);
    repeat (3) step();

    // Reset during a sweep aborts it.
    clear_start = 1'b1;
    step();
    clear_start = 1'b0;
    writes = 0;
    for (int i = 0; i < 200; i++) begin
      step();
      if (ram_wren) writes++;
      if (writes == 100) break;
    end
    chk("t5 reached write 100", writes, 100);
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk("t5 wren", ram_wren, 0);
    chk("t5 busy", clear_busy, 0);
    chk("t5 done", clear_done, 0);
    done_cnt = 0;
    repeat (5) begin
      step();
      if (clear_done) done_cnt++;
    end
    chk("t5 no done", done_cnt, 0);
    clear_start = 1'b1;
    step();
    clear_start = 1'b0;
    step();
    chk("t5 restart wren", ram_wren, 1);
    chk("t5 restart addr", ram_address, 15'h0000);
    reset = 1'b1;
    step();
    reset = 1'b0;
    step();

    // Reset while a read is in flight drops its rvalid.
    game_req  = 1'b1;
    game_addr = 15'h0081;
    #1;
    chk("t6 game_gnt", game_gnt, 1);
    step();
    game_req = 1'b0;
    reset    = 1'b1;
    step();
    reset    = 1'b0;
    done_cnt = 0;
    repeat (4) begin
      step();
      if (game_rvalid) done_cnt++;
    end
    chk("t6 no rvalid", done_cnt, 0);
    repeat (2) step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
